led_ramp_gen: RTL

Brightness-ramp generator that sits directly upstream of the LED glow PWM stage and drives its duty-cycle input. It produces a triangular "breathing" sequence of duty values (rise, hold bright, fall, hold dark) at a programmable step rate. Each new value is delivered over a valid/ready handshake, so the PWM stage can take updates only at its own period boundaries. Back-pressure stalls the ramp; it never drops or skips a value.

---
 rtl/led_ramp_gen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/led_ramp_gen.sv
// Breathing-ramp duty generator feeding the LED PWM stage: rise, hold bright, fall, hold dark.
// Latency: first duty STEP_CYCLES cycles after leaving IDLE; backpressure freezes the whole ramp (no drops).
module led_ramp_gen #(
    parameter int DUTY_W      = 8,
    parameter int STEP_CYCLES = 20000,
    parameter int STEP_SIZE   = 1,
    parameter int HOLD_STEPS  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              duty_ready,
    output logic              duty_valid,
    output logic [DUTY_W-1:0] duty,
    output logic [2:0]        phase,
    output logic              cycle_done
);

    localparam int PW = $clog2(STEP_CYCLES);
    localparam int HW = $clog2(HOLD_STEPS + 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX   = '1;
    localparam logic [DUTY_W:0]   STEP_EXT   = (DUTY_W + 1)'(STEP_SIZE);
    localparam logic [PW-1:0]     PRESC_LAST = PW'(STEP_CYCLES - 1);
    localparam logic [HW-1:0]     HOLD_LAST  = HW'(HOLD_STEPS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     presc, presc_nxt;
    logic [HW-1:0]     hold_cnt, hold_nxt;
    logic [DUTY_W-1:0] duty_nxt;
    logic              valid_nxt;
    logic              done_nxt;
    logic              stall;
    logic              tick;
    logic [DUTY_W:0]   rise_sum;
    logic [DUTY_W:0]   fall_diff;
    logic [DUTY_W-1:0] rise_val;
    logic [DUTY_W-1:0] fall_val;

    // One extra bit catches overflow/borrow so the ramp saturates instead of wrapping.
    assign rise_sum  = {1'b0, duty} + STEP_EXT;
    assign fall_diff = {1'b0, duty} - STEP_EXT;
    assign rise_val  = (rise_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : rise_sum[DUTY_W-1:0];
    assign fall_val  = fall_diff[DUTY_W] ? '0 : fall_diff[DUTY_W-1:0];

    assign stall = duty_valid && !duty_ready;
    assign tick  = (state != IDLE) && (presc == PRESC_LAST) && !stall;
    assign phase = state;

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        hold_nxt  = hold_cnt;
        duty_nxt  = duty;
        valid_nxt = duty_valid && !duty_ready;
        done_nxt  = 1'b0;

        if (!stall) begin
            if (state == IDLE) begin
                presc_nxt = '0;
            end else begin
                presc_nxt = tick ? '0 : presc + PW'(1);
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state_nxt = RISE;
                    end
                end
                RISE: begin
                    if (!en) begin
                        state_nxt = (duty == '0) ? IDLE : FALL;
                    end else if (tick) begin
                        duty_nxt  = rise_val;
                        valid_nxt = 1'b1;
                        if (rise_val == DUTY_MAX) begin
                            state_nxt = HOLD_HI;
                            hold_nxt  = '0;
                        end
                    end
                end
                HOLD_HI: begin
                    if (!en) begin
                        state_nxt = (duty == '0) ? IDLE : FALL;
                    end else if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_nxt = FALL;
                        end else begin
                            hold_nxt = hold_cnt + HW'(1);
                        end
                    end
                end
                FALL: begin
                    // Disable does not cut a fall short; it only redirects the end to IDLE.
                    if (tick) begin
                        duty_nxt  = fall_val;
                        valid_nxt = 1'b1;
                        if (fall_val == '0) begin
                            state_nxt = en ? HOLD_LO : IDLE;
                            hold_nxt  = '0;
                        end
                    end
                end
                HOLD_LO: begin
                    if (!en) begin
                        state_nxt = (duty == '0) ? IDLE : FALL;
                    end else if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_nxt = RISE;
                            done_nxt  = 1'b1;
                        end else begin
                            hold_nxt = hold_cnt + HW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            hold_cnt   <= '0;
            duty       <= '0;
            duty_valid <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            hold_cnt   <= hold_nxt;
            duty       <= duty_nxt;
            duty_valid <= valid_nxt;
            cycle_done <= done_nxt;
        end
    end

endmodule
